// File: rtl/lac_pkg.sv
`default_nettype none
// ============================================================================
// Module  : lac_pkg
// Brief   : Shared types and constants for the LAC receive-side deserializer.
// Revision: 1.0
// ============================================================================
package lac_pkg;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCKING  = 2'd1,
        LOCKED   = 2'd2
    } lac_state_t;

    typedef logic [1:0] lac_phase_t;

    localparam int WORDS_PER_FRAME = 4;

    // Bits needed to hold a count running from 0 up to n inclusive.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lac_align_monitor.sv
`default_nettype none
// ============================================================================
// Module  : lac_align_monitor
// Brief   : Phase counter, strobe lock FSM and saturating alignment-error log.
// Revision: 1.0
// ============================================================================
module lac_align_monitor
    import lac_pkg::*;
#(
    parameter int LOCK_COUNT = 4,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                 clock4x,
    input  logic                 reset_n,
    input  logic                 i_strobe,
    input  logic                 i_clear_err,
    output lac_phase_t           o_idx,
    output logic                 o_locked,
    output logic                 o_error,
    output logic                 o_align_err,
    output logic [ERR_CNT_W-1:0] o_err_cnt
);

    localparam int                   GOOD_W        = cnt_width(LOCK_COUNT);
    localparam logic [GOOD_W-1:0]    c_LOCK_TARGET = GOOD_W'(LOCK_COUNT);
    localparam logic [ERR_CNT_W-1:0] c_ERR_MAX     = '1;

    lac_state_t           r_state;
    lac_phase_t           r_phase;
    logic [GOOD_W-1:0]    r_good_cnt;
    logic                 r_locked;
    logic                 r_align_err;
    logic [ERR_CNT_W-1:0] r_err_cnt;

    lac_phase_t           w_idx;
    logic                 w_misalign;
    logic                 w_error;
    logic [GOOD_W-1:0]    w_good_next;

    // A strobe always forces index 0; otherwise the phase flywheels.
    assign w_idx       = i_strobe ? 2'd0 : r_phase;
    assign w_misalign  = i_strobe ^ (r_phase == 2'd0);
    assign w_error     = w_misalign && (r_state != UNLOCKED);
    assign w_good_next = r_good_cnt + GOOD_W'(1);

    always_ff @(posedge clock4x or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= UNLOCKED;
            r_phase    <= 2'd0;
            r_good_cnt <= '0;
            r_locked   <= 1'b0;
        end else begin
            r_phase <= w_idx + 2'd1;
            case (r_state)
                UNLOCKED: begin
                    if (i_strobe) begin
                        r_good_cnt <= GOOD_W'(1);
                        if (LOCK_COUNT == 1) begin
                            r_state  <= LOCKED;
                            r_locked <= 1'b1;
                        end else begin
                            r_state <= LOCKING;
                        end
                    end
                end
                LOCKING: begin
                    if (w_error) begin
                        r_state    <= UNLOCKED;
                        r_good_cnt <= '0;
                    end else if (i_strobe) begin
                        r_good_cnt <= w_good_next;
                        if (w_good_next == c_LOCK_TARGET) begin
                            r_state  <= LOCKED;
                            r_locked <= 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    if (w_error) begin
                        r_state    <= UNLOCKED;
                        r_good_cnt <= '0;
                        r_locked   <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= UNLOCKED;
                    r_good_cnt <= '0;
                    r_locked   <= 1'b0;
                end
            endcase
        end
    end

    // An error coincident with a clear is recorded after the clear.
    always_ff @(posedge clock4x or negedge reset_n) begin
        if (!reset_n) begin
            r_align_err <= 1'b0;
            r_err_cnt   <= '0;
        end else if (i_clear_err) begin
            r_align_err <= w_error;
            r_err_cnt   <= w_error ? ERR_CNT_W'(1) : '0;
        end else if (w_error) begin
            r_align_err <= 1'b1;
            if (r_err_cnt != c_ERR_MAX) begin
                r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
            end
        end
    end

    assign o_idx       = w_idx;
    assign o_locked    = r_locked;
    assign o_error     = w_error;
    assign o_align_err = r_align_err;
    assign o_err_cnt   = r_err_cnt;

endmodule
`default_nettype wire

// File: rtl/lac_deserializer.sv
`default_nettype none
// ============================================================================
// Module  : lac_deserializer
// Brief   : Collects four 4x-rate words into one held-stable wide frame.
// Revision: 1.0
// ============================================================================
module lac_deserializer
    import lac_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int LOCK_COUNT = 4,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                         clock4x,
    input  logic                         reset_n,
    input  logic                         strobe,
    input  logic [WIDTH-1:0]             din,
    input  logic                         din_valid,
    input  logic                         clear_err,
    output logic [WORDS_PER_FRAME*WIDTH-1:0] dout,
    output logic [WORDS_PER_FRAME-1:0]   dout_valid,
    output logic                         frame,
    output logic                         locked,
    output logic                         align_err,
    output logic [ERR_CNT_W-1:0]         err_cnt
);

    lac_phase_t                       w_idx;
    logic                             w_locked;
    logic                             w_error;

    logic [WIDTH-1:0]                 r_word0;
    logic [WIDTH-1:0]                 r_word1;
    logic [WIDTH-1:0]                 r_word2;
    logic [2:0]                       r_wvalid;
    logic [WORDS_PER_FRAME*WIDTH-1:0] r_dout;
    logic [WORDS_PER_FRAME-1:0]       r_dout_valid;
    logic                             r_frame;

    lac_align_monitor #(
        .LOCK_COUNT (LOCK_COUNT),
        .ERR_CNT_W  (ERR_CNT_W)
    ) u_monitor (
        .clock4x     (clock4x),
        .reset_n     (reset_n),
        .i_strobe    (strobe),
        .i_clear_err (clear_err),
        .o_idx       (w_idx),
        .o_locked    (w_locked),
        .o_error     (w_error),
        .o_align_err (align_err),
        .o_err_cnt   (err_cnt)
    );

    always_ff @(posedge clock4x or negedge reset_n) begin
        if (!reset_n) begin
            r_word0      <= '0;
            r_word1      <= '0;
            r_word2      <= '0;
            r_wvalid     <= '0;
            r_dout       <= '0;
            r_dout_valid <= '0;
            r_frame      <= 1'b0;
        end else begin
            r_frame <= 1'b0;
            case (w_idx)
                2'd0: begin
                    r_word0     <= din;
                    r_wvalid[0] <= din_valid;
                end
                2'd1: begin
                    r_word1     <= din;
                    r_wvalid[1] <= din_valid;
                end
                2'd2: begin
                    r_word2     <= din;
                    r_wvalid[2] <= din_valid;
                end
                default: begin
                end
            endcase
            // Word 3 goes straight from din to the output so the frame lands
            // on the same edge that samples it.
            if (w_idx == 2'd3 && w_locked && !w_error) begin
                r_dout       <= {din, r_word2, r_word1, r_word0};
                r_dout_valid <= {din_valid, r_wvalid};
                r_frame      <= 1'b1;
            end else if (w_locked && w_error) begin
                r_dout_valid <= '0;
            end
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign frame      = r_frame;
    assign locked     = w_locked;

endmodule
`default_nettype wire

// File: tb/tb_lac_deserializer.sv
`default_nettype none
// ============================================================================
// Module  : tb_lac_deserializer
// Brief   : Directed self-checking bench for lac_deserializer.
// Revision: 1.0
// ============================================================================
module tb_lac_deserializer;

    logic        clock4x = 1'b0;
    logic        reset_n;
    logic        strobe;
    logic [7:0]  din;
    logic        din_valid;
    logic        clear_err;
    logic [31:0] dout;
    logic [3:0]  dout_valid;
    logic        frame;
    logic        locked;
    logic        align_err;
    logic [1:0]  err_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    lac_deserializer #(
        .WIDTH      (8),
        .LOCK_COUNT (4),
        .ERR_CNT_W  (2)
    ) dut (
        .clock4x    (clock4x),
        .reset_n    (reset_n),
        .strobe     (strobe),
        .din        (din),
        .din_valid  (din_valid),
        .clear_err  (clear_err),
        .dout       (dout),
        .dout_valid (dout_valid),
        .frame      (frame),
        .locked     (locked),
        .align_err  (align_err),
        .err_cnt    (err_cnt)
    );

    always #5 clock4x = ~clock4x;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cycle(input logic s, input logic [7:0] d, input logic v, input logic clr);
        strobe    = s;
        din       = d;
        din_valid = v;
        clear_err = clr;
        @(posedge clock4x);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] base, input logic [3:0] vmask);
        cycle(1'b1, base, vmask[0], 1'b0);
        for (int i = 1; i < 4; i++) begin
            cycle(1'b0, base + 8'(i), vmask[i], 1'b0);
        end
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_dout"},   64'(dout),       64'h0);
        check_eq({tag, "_dvalid"}, 64'(dout_valid), 64'h0);
        check_eq({tag, "_frame"},  64'(frame),      64'h0);
        check_eq({tag, "_locked"}, 64'(locked),     64'h0);
        check_eq({tag, "_aerr"},   64'(align_err),  64'h0);
        check_eq({tag, "_ecnt"},   64'(err_cnt),    64'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n   = 1'b0;
        strobe    = 1'b0;
        din       = 8'h00;
        din_valid = 1'b0;
        clear_err = 1'b0;
        repeat (3) @(posedge clock4x);
        #1;
        check_idle("reset");
        reset_n = 1'b1;

        // Acquire lock: the fourth strobe locks and its frame is the first out.
        for (int f = 0; f < 3; f++) send_frame(8'h10, 4'hF);
        check_eq("prelock_locked", 64'(locked), 64'h0);
        check_eq("prelock_dout",   64'(dout),   64'h0);
        cycle(1'b1, 8'h10, 1'b1, 1'b0);
        check_eq("lock_rise", 64'(locked), 64'h1);
        cycle(1'b0, 8'h11, 1'b1, 1'b0);
        cycle(1'b0, 8'h12, 1'b1, 1'b0);
        check_eq("first_frame_early", 64'(frame), 64'h0);
        cycle(1'b0, 8'h13, 1'b1, 1'b0);
        check_eq("first_dout",   64'(dout),       64'h13121110);
        check_eq("first_dvalid", 64'(dout_valid), 64'hF);
        check_eq("first_frame",  64'(frame),      64'h1);
        cycle(1'b1, 8'h20, 1'b1, 1'b0);
        check_eq("hold_frame", 64'(frame), 64'h0);
        check_eq("hold_dout",  64'(dout),  64'h13121110);
        for (int i = 1; i < 4; i++) cycle(1'b0, 8'h20 + 8'(i), 1'b1, 1'b0);
        check_eq("second_dout",  64'(dout),  64'h23222120);
        check_eq("second_frame", 64'(frame), 64'h1);

        // Per-word valid with word 2 invalid.
        send_frame(8'h30, 4'b1011);
        check_eq("pwv_dvalid", 64'(dout_valid), 64'hB);
        check_eq("pwv_dout",   64'(dout),       64'h33323130);

        // Early strobe at phase 3 breaks lock and drops the partial frame.
        cycle(1'b1, 8'h40, 1'b1, 1'b0);
        cycle(1'b0, 8'h41, 1'b1, 1'b0);
        cycle(1'b0, 8'h42, 1'b1, 1'b0);
        cycle(1'b1, 8'h50, 1'b1, 1'b0);
        check_eq("early_locked", 64'(locked),     64'h0);
        check_eq("early_dvalid", 64'(dout_valid), 64'h0);
        check_eq("early_aerr",   64'(align_err),  64'h1);
        check_eq("early_ecnt",   64'(err_cnt),    64'h1);
        check_eq("early_dout",   64'(dout),       64'h33323130);
        for (int i = 1; i < 4; i++) cycle(1'b0, 8'h50 + 8'(i), 1'b1, 1'b0);
        check_eq("early_noframe", 64'(frame), 64'h0);
        check_eq("early_nodout",  64'(dout),  64'h33323130);
        for (int f = 0; f < 3; f++) send_frame(8'h60, 4'hF);
        check_eq("early_relock_pre", 64'(locked),  64'h0);
        check_eq("early_ecnt_hold",  64'(err_cnt), 64'h1);
        send_frame(8'h70, 4'hF);
        check_eq("early_relock", 64'(locked), 64'h1);
        check_eq("early_rdout",  64'(dout),   64'h73727170);
        check_eq("early_rframe", 64'(frame),  64'h1);

        // Missing strobe: counted once, phase flywheels, frame dropped.
        cycle(1'b0, 8'h80, 1'b1, 1'b0);
        check_eq("miss_locked", 64'(locked),     64'h0);
        check_eq("miss_ecnt",   64'(err_cnt),    64'h2);
        check_eq("miss_dvalid", 64'(dout_valid), 64'h0);
        for (int i = 1; i < 4; i++) cycle(1'b0, 8'h80 + 8'(i), 1'b1, 1'b0);
        check_eq("miss_noframe", 64'(frame), 64'h0);
        check_eq("miss_ecnt2",   64'(err_cnt), 64'h2);
        send_frame(8'h90, 4'hF);
        send_frame(8'hA0, 4'hF);
        send_frame(8'hB0, 4'hF);
        check_eq("miss_relock_pre", 64'(locked), 64'h0);
        send_frame(8'hC0, 4'hF);
        check_eq("miss_relock", 64'(locked),     64'h1);
        check_eq("miss_rdout",  64'(dout),       64'hC3C2C1C0);
        check_eq("miss_rdval",  64'(dout_valid), 64'hF);

        // Saturation: errors three through five on a 2-bit counter.
        cycle(1'b1, 8'h00, 1'b1, 1'b0);
        cycle(1'b1, 8'h00, 1'b1, 1'b0);
        check_eq("sat_ecnt3", 64'(err_cnt), 64'h3);
        cycle(1'b1, 8'h00, 1'b1, 1'b0);
        cycle(1'b1, 8'h00, 1'b1, 1'b0);
        check_eq("sat_ecnt4", 64'(err_cnt), 64'h3);
        cycle(1'b1, 8'h00, 1'b1, 1'b0);
        cycle(1'b1, 8'h00, 1'b1, 1'b0);
        check_eq("sat_ecnt5", 64'(err_cnt),   64'h3);
        check_eq("sat_aerr",  64'(align_err), 64'h1);
        cycle(1'b1, 8'h00, 1'b1, 1'b0);
        cycle(1'b1, 8'h00, 1'b1, 1'b1);
        check_eq("clr_err_ecnt", 64'(err_cnt),   64'h1);
        check_eq("clr_err_aerr", 64'(align_err), 64'h1);
        cycle(1'b0, 8'h00, 1'b1, 1'b1);
        check_eq("clr_ecnt", 64'(err_cnt),   64'h0);
        check_eq("clr_aerr", 64'(align_err), 64'h0);

        // Async reset in the middle of a frame.
        for (int f = 0; f < 4; f++) send_frame(8'hD0, 4'hF);
        check_eq("rst_pre_locked", 64'(locked), 64'h1);
        check_eq("rst_pre_dout",   64'(dout),   64'hD3D2D1D0);
        cycle(1'b1, 8'hE0, 1'b1, 1'b0);
        cycle(1'b0, 8'hE1, 1'b1, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        check_idle("async_rst");
        #2;
        reset_n = 1'b1;
        for (int f = 0; f < 3; f++) send_frame(8'hF0, 4'hF);
        check_eq("post_rst_dout",   64'(dout),   64'h0);
        check_eq("post_rst_locked", 64'(locked), 64'h0);
        send_frame(8'hF0, 4'hF);
        check_eq("post_rst_relock", 64'(locked), 64'h1);
        check_eq("post_rst_rdout",  64'(dout),   64'hF3F2F1F0);
        check_eq("post_rst_frame",  64'(frame),  64'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
